// File: rtl/csi_lane_rx.sv
// csi_lane_rx: single-lane CSI D-PHY data-lane receiver.
// Decodes the LP11 -> LP01 -> LP00 start-of-transmission sequence, hunts the
// HS sync byte 0xB8 on the sampled HS bit stream and deserializes HS bits into
// WORD_W-bit words, LSB first.
//
// Optional build macro: CSI_LANE_RX_SYNC_TOL_EN. When defined, a sync register
// at Hamming distance 1 from 0xB8 is accepted as a corrected match (sot and
// sot_err pulse together). When undefined, only an exact match is accepted.
//
// Output handshake: word_valid is a one-cycle strobe qualifying word_data.
// There is no ready input; the downstream decoder must accept every word in
// the cycle it is presented. sot, eot and sot_err are one-cycle pulses.
//
// state_dbg exposes the FSM state: 0 STOP, 1 HS_RQST, 2 HS_PREP, 3 HS_SYNC,
// 4 HS_DATA.
module csi_lane_rx #(
  parameter int WORD_W      = 8,
  parameter int PREPARE_MAX = 16,
  parameter int SYNC_MAX    = 32,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lp_p,
  input  logic              lp_n,
  input  logic              hs_bit,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              sot,
  output logic              eot,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              sot_err,
  output logic              rx_active,
  output logic [2:0]        state_dbg
);

  localparam int PREP_W = $clog2(PREPARE_MAX);
  localparam int SYNC_W = $clog2(SYNC_MAX);
  localparam int BIT_W  = $clog2(WORD_W);

  localparam logic [7:0]        SYNC_BYTE = 8'hB8;
  localparam logic [PREP_W-1:0] PREP_LAST = PREP_W'(PREPARE_MAX - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_MAX - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);

  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP11 = 2'b11;

  typedef enum logic [2:0] {
    ST_STOP = 3'd0,
    ST_RQST = 3'd1,
    ST_PREP = 3'd2,
    ST_SYNC = 3'd3,
    ST_DATA = 3'd4
  } state_t;

  state_t            state;
  logic [PREP_W-1:0] prep_cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [7:0]        sync_sr;
  logic [WORD_W-1:0] data_sr;

  logic [1:0]        lp;
  logic [7:0]        sync_next;
  logic [WORD_W-1:0] data_next;
  logic              sync_exact;
  logic              sync_near;

  assign lp        = {lp_p, lp_n};
  // New bits enter at the MSB so the first received bit ends up at bit 0.
  assign sync_next = {hs_bit, sync_sr[7:1]};
  assign data_next = {hs_bit, data_sr[WORD_W-1:1]};
  assign sync_exact = (sync_next == SYNC_BYTE);

`ifdef CSI_LANE_RX_SYNC_TOL_EN
  assign sync_near = ($countones(sync_next ^ SYNC_BYTE) == 1);
`else
  assign sync_near = 1'b0;
`endif

  assign state_dbg = state;

  // Lane FSM with all outputs registered; pulse outputs default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_STOP;
      prep_cnt   <= '0;
      sync_cnt   <= '0;
      bit_cnt    <= '0;
      sync_sr    <= '0;
      data_sr    <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      sot        <= 1'b0;
      eot        <= 1'b0;
      sot_err    <= 1'b0;
      rx_active  <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      word_valid <= 1'b0;
      sot        <= 1'b0;
      eot        <= 1'b0;
      sot_err    <= 1'b0;
      case (state)
        ST_STOP: begin
          // Escape requests (LP10) and stray LP00 are not ours to answer.
          if (lp == LP01) state <= ST_RQST;
        end
        ST_RQST: begin
          case (lp)
            LP00: begin
              // The LP00 cycle that leaves the request counts as prepare cycle 1.
              state    <= ST_PREP;
              prep_cnt <= PREP_W'(1);
            end
            LP11: state <= ST_STOP;
            LP10: begin
              state   <= ST_STOP;
              sot_err <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_PREP: begin
          if (lp != LP00) begin
            state    <= ST_STOP;
            sot_err  <= 1'b1;
            prep_cnt <= '0;
          end else begin
            sync_sr <= sync_next;
            if (prep_cnt == PREP_LAST) begin
              state     <= ST_SYNC;
              prep_cnt  <= '0;
              sync_cnt  <= '0;
              sync_sr   <= '0;
              rx_active <= 1'b1;
            end else begin
              prep_cnt <= prep_cnt + 1'b1;
            end
          end
        end
        ST_SYNC: begin
          if (lp != LP00) begin
            state     <= ST_STOP;
            sot_err   <= 1'b1;
            rx_active <= 1'b0;
          end else begin
            sync_sr <= sync_next;
            if (sync_exact || sync_near) begin
              state    <= ST_DATA;
              sot      <= 1'b1;
              sot_err  <= ~sync_exact;
              bit_cnt  <= '0;
              data_sr  <= '0;
              byte_cnt <= '0;
            end else if (sync_cnt == SYNC_LAST) begin
              state     <= ST_STOP;
              sot_err   <= 1'b1;
              rx_active <= 1'b0;
            end else begin
              sync_cnt <= sync_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          // LP takes priority: hs_bit on the exit cycle and any trail bits are dropped.
          if (lp == LP11) begin
            state     <= ST_STOP;
            eot       <= 1'b1;
            rx_active <= 1'b0;
          end else if (lp != LP00) begin
            state     <= ST_STOP;
            eot       <= 1'b1;
            sot_err   <= 1'b1;
            rx_active <= 1'b0;
          end else begin
            data_sr <= data_next;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt    <= '0;
              word_data  <= data_next;
              word_valid <= 1'b1;
              if (byte_cnt != {CNT_W{1'b1}}) byte_cnt <= byte_cnt + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_STOP;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
